// File: rtl/fsqrt_arbiter_pkg.sv
// Shared types and constants for the fsqrt round-robin arbiter slice.
package fsqrt_arbiter_pkg;

  localparam int FSQRT_LAT_DEF = 4;
  localparam int N_REQ_DEF     = 4;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Requester-ID width; a single bit is kept even for tiny configurations.
  function automatic int req_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsqrt_arbiter_if.sv
// Requester-side and fsqrt-side bundle of the arbiter; slave = arbiter view.
interface fsqrt_arbiter_if #(
  parameter int N_REQ = 4
);
  import fsqrt_arbiter_pkg::*;

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ-1:0]    resp_valid;
  fp32_t               resp_data;
  fp32_t               fs_input_a;
  logic                fs_input_valid;
  fp32_t               fs_result;
  logic                fs_out_valid;

  modport slave (
    input  req_valid, req_a, fs_result, fs_out_valid,
    output req_ready, resp_valid, resp_data, fs_input_a, fs_input_valid
  );

  modport master (
    output req_valid, req_a, fs_result, fs_out_valid,
    input  req_ready, resp_valid, resp_data, fs_input_a, fs_input_valid
  );

endinterface

// File: rtl/fsqrt_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, else lowest overall.
module rr_arbiter
  import fsqrt_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = req_id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);

  always_comb begin
    logic [N-1:0] upper;
    logic [N-1:0] pick;
    // NOTE: every output gets a default before any branch, otherwise a latch is inferred.
    upper    = '0;
    grant    = '0;
    grant_id = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = req[i] && (IW'(i) >= ptr);
    end
    pick = (upper != '0) ? upper : req;
    if (en) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pick[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          grant_id = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/fsqrt_arbiter.sv
// Round-robin sharing of one pipelined fsqrt among N_REQ requesters, with ID tag pipe.
// Optional FSQRT_ARB_STATS_EN adds per-requester issue counters and a conflict counter.
module fsqrt_arbiter
  import fsqrt_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int FSQRT_LAT = FSQRT_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  fsqrt_arbiter_if.slave      bus,
  output logic                busy,
  output logic                tag_err
`ifdef FSQRT_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0] stat_issue,
  output logic [15:0]         stat_conflict
`endif
);

  localparam int IW = req_id_w(N_REQ);
  localparam int CW = $clog2(FSQRT_LAT + 2);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_t;

  arb_state_e       r_state;
  logic             r_busy;
  logic [IW-1:0]    r_ptr;
  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_grant_id;
  logic             w_hs;
  fp32_t            w_req_a;
  fp32_t            r_fs_a;
  logic             r_fs_valid;
  logic [IW-1:0]    r_issue_id;
  tag_t             r_tag [FSQRT_LAT];
  tag_t             w_tail;
  logic             w_retire_ok;
  logic [CW-1:0]    r_inflight;
  logic [N_REQ-1:0] r_resp_valid;
  fp32_t            r_resp_data;
  logic             r_tag_err;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req      (bus.req_valid),
    .ptr      (r_ptr),
    .en       (r_state == RUN),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

  // The grant is already masked by req_valid, so any grant bit is a handshake.
  assign w_hs = |w_grant;

  always_comb begin
    w_req_a = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_req_a = bus.req_a[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      case (r_state)
        IDLE: if (en) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
        RUN: if (!en) r_state <= DRAIN;
        DRAIN: begin
          if (en) begin
            r_state <= RUN;
          end else if (r_inflight == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_fs_valid <= 1'b0;
      r_fs_a     <= '0;
      r_issue_id <= '0;
    end else begin
      r_fs_valid <= w_hs;
      if (w_hs) begin
        r_fs_a     <= w_req_a;
        r_issue_id <= w_grant_id;
        r_ptr      <= (w_grant_id == IW'(N_REQ - 1)) ? '0 : w_grant_id + IW'(1);
      end
    end
  end

  // Stage 0 captures the tag on the same edge the fsqrt samples input_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag pipe is reset because a stale valid bit would retire a phantom op.
      for (int k = 0; k < FSQRT_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= '{valid: r_fs_valid, id: r_issue_id};
      for (int k = 1; k < FSQRT_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_tail      = r_tag[FSQRT_LAT-1];
  assign w_retire_ok = bus.fs_out_valid & w_tail.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_tag_err    <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      if (w_retire_ok) begin
        r_resp_valid <= N_REQ'(1) << w_tail.id;
        r_resp_data  <= bus.fs_result;
      end
      if (bus.fs_out_valid != w_tail.valid) r_tag_err <= 1'b1;
    end
  end

  // A tag leaving the pipe retires its slot even if out_valid went missing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_hs, w_tail.valid})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.req_ready      = w_grant;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_data      = r_resp_data;
  assign bus.fs_input_a     = r_fs_a;
  assign bus.fs_input_valid = r_fs_valid;
  assign busy               = r_busy;
  assign tag_err            = r_tag_err;

`ifdef FSQRT_ARB_STATS_EN
  logic [15:0] r_stat_issue [N_REQ];
  logic [15:0] r_stat_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) r_stat_issue[i] <= '0;
      r_stat_conflict <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_grant[i]) r_stat_issue[i] <= r_stat_issue[i] + 16'd1;
      end
      if (r_state == RUN && $countones(bus.req_valid) >= 2) begin
        r_stat_conflict <= r_stat_conflict + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_issue[16*g +: 16] = r_stat_issue[g];
  end
  assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Directed bench for fsqrt_arbiter with a table-driven fsqrt model of fixed latency.
module tb_fsqrt_arbiter;
  import fsqrt_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic busy;
  logic tag_err;
  logic r_force;
  logic [N-1:0] sticky;

  always #5 clk = ~clk;

  fsqrt_arbiter_if #(.N_REQ(N)) bus ();

`ifdef FSQRT_ARB_STATS_EN
  logic [N*16-1:0] stat_issue;
  logic [15:0]     stat_conflict;
`endif

  fsqrt_arbiter #(.N_REQ(N), .FSQRT_LAT(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .bus     (bus),
    .busy    (busy),
    .tag_err (tag_err)
`ifdef FSQRT_ARB_STATS_EN
    ,
    .stat_issue    (stat_issue),
    .stat_conflict (stat_conflict)
`endif
  );

  function automatic fp32_t sqrt_ref(input fp32_t a);
    case (a)
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      32'h41800000: return 32'h40800000;
      32'h3F800000: return 32'h3F800000;
      32'h3E800000: return 32'h3F000000;
      default:      return 32'h7FC00000;
    endcase
  endfunction

  // Fixed-latency fsqrt stand-in, sharing the arbiter's reset.
  logic  fm_v [LAT];
  fp32_t fm_d [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        fm_v[k] <= 1'b0;
        fm_d[k] <= '0;
      end
    end else begin
      fm_v[0] <= bus.fs_input_valid;
      fm_d[0] <= sqrt_ref(bus.fs_input_a);
      for (int k = 1; k < LAT; k++) begin
        fm_v[k] <= fm_v[k-1];
        fm_d[k] <= fm_d[k-1];
      end
    end
  end
  assign bus.fs_out_valid = fm_v[LAT-1] | r_force;
  assign bus.fs_result    = fm_d[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [N-1:0] hs_mask;
  int    g_id[$];
  int    g_cyc[$];
  int    r_id[$];
  int    r_cyc[$];
  fp32_t r_data[$];
  int    onehot_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_mask = '0;
    end else begin
      hs_mask = bus.req_valid & bus.req_ready;
      for (int i = 0; i < N; i++) begin
        if (hs_mask[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      if (bus.resp_valid != '0) begin
        if ($countones(bus.resp_valid) != 1) onehot_bad = onehot_bad + 1;
        for (int i = 0; i < N; i++) begin
          if (bus.resp_valid[i]) begin
            r_id.push_back(i);
            r_cyc.push_back(cyc);
            r_data.push_back(bus.resp_data);
          end
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; a granted requester drops valid unless it is marked sticky.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~(hs_mask & ~sticky);
  endtask

  task automatic wait_resp(input int target, input int budget);
    for (int i = 0; i < budget && r_id.size() < target; i++) tick();
  endtask

  task automatic do_reset();
    en            = 1'b0;
    bus.req_valid = '0;
    sticky        = '0;
    rst_n         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int base_g;
  int base_r;
  int nresp;
  int bad_busy;
  int ready_seen;
  fp32_t t2_exp [4] = '{32'h40400000, 32'h40800000, 32'h3F800000, 32'h3F000000};
  int    t3_id  [4] = '{1, 3, 1, 3};
  fp32_t t3_exp [4] = '{32'h40800000, 32'h3F000000, 32'h40800000, 32'h3F000000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    en            = 1'b0;
    r_force       = 1'b0;
    sticky        = '0;
    bus.req_valid = '0;
    bus.req_a     = '0;

    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_fs_valid", bus.fs_input_valid, 0);
    check("rst_fs_a", bus.fs_input_a, 0);
    check("rst_busy", busy, 0);
    check("rst_tag_err", tag_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1) single request: sqrt(4.0)
    en = 1'b1;
    tick();
    bus.req_a[31:0]  = 32'h40800000;
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_ready", bus.req_ready, 4'b0001);
    tick();
    @(negedge clk);
    check("t1_fs_valid", bus.fs_input_valid, 1);
    check("t1_fs_a", bus.fs_input_a, 32'h40800000);
    tick();
    @(negedge clk);
    check("t1_fs_valid_off", bus.fs_input_valid, 0);
    check("t1_fs_a_hold", bus.fs_input_a, 32'h40800000);
    wait_resp(1, 20);
    check("t1_grants", g_id.size(), 1);
    check("t1_resp_cnt", r_id.size(), 1);
    if (r_id.size() >= 1 && g_id.size() >= 1) begin
      check("t1_resp_id", r_id[0], 0);
      check("t1_resp_data", r_data[0], 32'h40000000);
      check("t1_latency", r_cyc[0] - g_cyc[0], LAT + 2);
    end

    // 2) all four requesters at once, pointer at 0
    do_reset();
    en = 1'b1;
    tick();
    base_g        = g_id.size();
    base_r        = r_id.size();
    bus.req_a     = {32'h3E800000, 32'h3F800000, 32'h41800000, 32'h41100000};
    bus.req_valid = 4'hF;
    repeat (4) tick();
    check("t2_grants", g_id.size() - base_g, 4);
    wait_resp(base_r + 4, 20);
    check("t2_resp_cnt", r_id.size() - base_r, 4);
    if (g_id.size() - base_g == 4 && r_id.size() - base_r == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t2_grant_id%0d", k), g_id[base_g+k], k);
        check($sformatf("t2_grant_cyc%0d", k), g_cyc[base_g+k] - g_cyc[base_g], k);
        check($sformatf("t2_resp_id%0d", k), r_id[base_r+k], k);
        check($sformatf("t2_resp_data%0d", k), r_data[base_r+k], t2_exp[k]);
        check($sformatf("t2_resp_cyc%0d", k), r_cyc[base_r+k] - r_cyc[base_r], k);
      end
    end

    // 3) requesters 1 and 3 held valid, pointer back at 0
    base_g        = g_id.size();
    base_r        = r_id.size();
    sticky        = 4'b1010;
    bus.req_valid = 4'b1010;
    repeat (4) tick();
    bus.req_valid = '0;
    sticky        = '0;
    check("t3_grants", g_id.size() - base_g, 4);
    wait_resp(base_r + 4, 20);
    check("t3_resp_cnt", r_id.size() - base_r, 4);
    if (g_id.size() - base_g == 4 && r_id.size() - base_r == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t3_grant_id%0d", k), g_id[base_g+k], t3_id[k]);
        check($sformatf("t3_resp_id%0d", k), r_id[base_r+k], t3_id[k]);
        check($sformatf("t3_resp_data%0d", k), r_data[base_r+k], t3_exp[k]);
      end
    end

    // 4) three issues, then en dropped; drain with a requester waiting
    base_g        = g_id.size();
    base_r        = r_id.size();
    bus.req_a[95:0] = {32'h41800000, 32'h41100000, 32'h40800000};
    bus.req_valid = 4'b0111;
    repeat (3) tick();
    tick();
    en = 1'b0;
    tick();
    bus.req_valid[3] = 1'b1;
    sticky[3]        = 1'b1;
    nresp      = 0;
    bad_busy   = 0;
    ready_seen = 0;
    for (int i = 0; i < 40 && nresp < 3; i++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) nresp = nresp + 1;
      if (!busy) bad_busy = bad_busy + 1;
      if (bus.req_ready != '0) ready_seen = ready_seen + 1;
      if (nresp < 3) tick();
    end
    tick();
    @(negedge clk);
    check("t4_grants", g_id.size() - base_g, 3);
    check("t4_resp_cnt", nresp, 3);
    check("t4_busy_during_drain", bad_busy, 0);
    check("t4_no_ready_in_drain", ready_seen, 0);
    check("t4_idle_after", busy, 0);
    check("t4_ready_idle", bus.req_ready, 0);
    bus.req_valid = '0;
    sticky        = '0;

    // 5) reset with two ops in flight
    en = 1'b1;
    tick();
    bus.req_valid = 4'b0011;
    tick();
    tick();
    tick();
    rst_n  = 1'b0;
    en     = 1'b0;
    base_r = r_id.size();
    @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_resp", bus.resp_valid, 0);
    check("t5_rst_fs_valid", bus.fs_input_valid, 0);
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("t5_no_resp", r_id.size() - base_r, 0);
    check("t5_tag_err", tag_err, 0);
    check("t5_inflight", dut.r_inflight, 0);
    check("t5_busy", busy, 0);

`ifdef FSQRT_ARB_STATS_EN
    // stats: five grants to requester 2
    en = 1'b1;
    tick();
    bus.req_a[95:64] = 32'h3F800000;
    sticky           = 4'b0100;
    bus.req_valid    = 4'b0100;
    repeat (5) tick();
    bus.req_valid = '0;
    sticky        = '0;
    tick();
    check("stat_issue2", stat_issue[47:32], 5);
    check("stat_issue0", stat_issue[15:0], 0);
    check("stat_conflict", stat_conflict, 0);
    en = 1'b0;
    repeat (15) tick();
    check("stat_tag_err", tag_err, 0);
`endif

    // 6) spurious out_valid with an empty tag pipe
    base_r  = r_id.size();
    r_force = 1'b1;
    tick();
    r_force = 1'b0;
    @(negedge clk);
    check("t6_tag_err", tag_err, 1);
    check("t6_resp", bus.resp_valid, 0);
    repeat (3) tick();
    @(negedge clk);
    check("t6_tag_err_sticky", tag_err, 1);
    check("t6_no_resp", r_id.size() - base_r, 0);

    check("resp_onehot", onehot_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
